// File: rtl/mips_pkg.sv
// Shared opcode/funct constants and instruction field helpers for the
// mipspipe_fwd core and its hazard unit.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  localparam logic [5:0] F_ADD = 6'd32;
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_AND = 6'd36;
  localparam logic [5:0] F_OR  = 6'd37;
  localparam logic [5:0] F_SLT = 6'd42;

  // add $0,$0,$0: architecturally a no-op because $0 is never written
  localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  function automatic logic [5:0] ir_op(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] ir_rs(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] ir_rt(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] ir_rd(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [5:0] ir_funct(input logic [31:0] ir);
    return ir[5:0];
  endfunction

  function automatic logic [15:0] ir_imm(input logic [31:0] ir);
    return ir[15:0];
  endfunction

  function automatic logic alu_funct(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
  endfunction

  function automatic logic writes_reg(input logic [31:0] ir);
    return ((ir_op(ir) == OP_RTYPE) && alu_funct(ir_funct(ir))) || (ir_op(ir) == OP_LW);
  endfunction

  function automatic logic [4:0] ir_dest(input logic [31:0] ir);
    return (ir_op(ir) == OP_LW) ? ir_rt(ir) : ir_rd(ir);
  endfunction

  function automatic logic uses_rt(input logic [31:0] ir);
    return (ir_op(ir) == OP_RTYPE) || (ir_op(ir) == OP_SW) || (ir_op(ir) == OP_BEQ);
  endfunction

  // True when prod writes a nonzero register that cons reads as a source
  function automatic logic feeds(input logic [31:0] prod, input logic [31:0] cons);
    logic [4:0] d;
    d = ir_dest(prod);
    return writes_reg(prod) && (d != 5'd0) &&
           ((d == ir_rs(cons)) || (uses_rt(cons) && (d == ir_rt(cons))));
  endfunction

endpackage

// File: rtl/mips_hazard_unit.sv
// Combinational hazard detection: load-use / interlock stall request and
// ALU operand forwarding selects for the EX stage.
module mips_hazard_unit
  import mips_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic [31:0] ifid_ir,
  input  logic [31:0] idex_ir,
  input  logic [31:0] exmem_ir,
  input  logic [31:0] memwb_ir,
  output logic        stall,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel
);

  logic exmem_src;
  logic memwb_src;
  logic load_use;
  logic interlock;

  // not every stage looks at every field
  logic unused_fields;
  assign unused_fields = ^{ifid_ir, idex_ir, exmem_ir, memwb_ir};

  always_comb begin
    // an EX/MEM load has no data yet, so only R-type results forward from there
    exmem_src = FWD_EN && (ir_op(exmem_ir) == OP_RTYPE) && writes_reg(exmem_ir) &&
                (ir_dest(exmem_ir) != 5'd0);
    memwb_src = FWD_EN && writes_reg(memwb_ir) && (ir_dest(memwb_ir) != 5'd0);

    fwd_a_sel = FWD_REG;
    if (exmem_src && (ir_dest(exmem_ir) == ir_rs(idex_ir)))
      fwd_a_sel = FWD_EXMEM;
    else if (memwb_src && (ir_dest(memwb_ir) == ir_rs(idex_ir)))
      fwd_a_sel = FWD_MEMWB;

    fwd_b_sel = FWD_REG;
    if (exmem_src && (ir_dest(exmem_ir) == ir_rt(idex_ir)))
      fwd_b_sel = FWD_EXMEM;
    else if (memwb_src && (ir_dest(memwb_ir) == ir_rt(idex_ir)))
      fwd_b_sel = FWD_MEMWB;

    load_use  = (ir_op(idex_ir) == OP_LW) && feeds(idex_ir, ifid_ir);
    interlock = feeds(idex_ir, ifid_ir) || feeds(exmem_ir, ifid_ir) || feeds(memwb_ir, ifid_ir);
    stall     = FWD_EN ? load_use : interlock;
  end

endmodule

// File: rtl/mipspipe_fwd.sv
// Five-stage MIPS subset core with forwarding/interlock, load-use stall,
// BEQ flush in EX, reset-time memory load port and a WB retire trace.
module mipspipe_fwd
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ld_we,
  input  logic        ld_sel,
  input  logic [9:0]  ld_addr,
  input  logic [31:0] ld_wdata,
  output logic [31:0] pc_o,
  output logic        stall_o,
  output logic        ret_valid,
  output logic [4:0]  ret_reg,
  output logic [31:0] ret_data
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
  localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] regs [32];

  logic [31:0] pc;
  logic [31:0] ifid_ir, ifid_pc;
  logic [31:0] idex_ir, idex_pc, idex_a, idex_b;
  logic [31:0] exmem_ir, exmem_alu, exmem_b;
  logic [31:0] memwb_ir, memwb_val;

  logic        stall;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] id_a, id_b;
  logic [31:0] ex_a, ex_b, ex_imm, ex_alu, ex_target;
  logic        ex_taken;
  logic [DW-1:0] dmem_idx;
  logic [31:0] mem_val;

  mips_hazard_unit #(.FWD_EN(FWD_EN)) u_hazard (
    .ifid_ir   (ifid_ir),
    .idex_ir   (idex_ir),
    .exmem_ir  (exmem_ir),
    .memwb_ir  (memwb_ir),
    .stall     (stall),
    .fwd_a_sel (fwd_a_sel),
    .fwd_b_sel (fwd_b_sel)
  );

  assign wb_dest   = ir_dest(memwb_ir);
  assign wb_we     = writes_reg(memwb_ir) && (wb_dest != 5'd0);
  assign ret_valid = wb_we;
  assign ret_reg   = wb_we ? wb_dest : 5'd0;
  assign ret_data  = wb_we ? memwb_val : 32'd0;
  assign pc_o      = pc;
  // a taken branch flushes IF/ID instead of holding it
  assign stall_o   = stall && !ex_taken;

  // register read with write-through from WB
  always_comb begin
    id_a = regs[ir_rs(ifid_ir)];
    id_b = regs[ir_rt(ifid_ir)];
    if (wb_we && (wb_dest == ir_rs(ifid_ir))) id_a = memwb_val;
    if (wb_we && (wb_dest == ir_rt(ifid_ir))) id_b = memwb_val;
  end

  always_comb begin
    case (fwd_a_sel)
      FWD_EXMEM: ex_a = exmem_alu;
      FWD_MEMWB: ex_a = memwb_val;
      default:   ex_a = idex_a;
    endcase
    case (fwd_b_sel)
      FWD_EXMEM: ex_b = exmem_alu;
      FWD_MEMWB: ex_b = memwb_val;
      default:   ex_b = idex_b;
    endcase
    ex_imm = {{16{idex_ir[15]}}, ir_imm(idex_ir)};
    ex_alu = ex_a + ex_imm;
    if (ir_op(idex_ir) == OP_RTYPE) begin
      case (ir_funct(idex_ir))
        F_ADD:   ex_alu = ex_a + ex_b;
        F_SUB:   ex_alu = ex_a - ex_b;
        F_AND:   ex_alu = ex_a & ex_b;
        F_OR:    ex_alu = ex_a | ex_b;
        F_SLT:   ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
        default: ex_alu = 32'd0;
      endcase
    end
    ex_taken  = (ir_op(idex_ir) == OP_BEQ) && (ex_a == ex_b);
    ex_target = (idex_pc + 32'd4 + {ex_imm[29:0], 2'b00}) & PC_MASK;
  end

  assign dmem_idx = exmem_alu[DW+1:2];
  assign mem_val  = (ir_op(exmem_ir) == OP_LW) ? dmem[dmem_idx] : exmem_alu;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc        <= 32'd0;
      ifid_ir   <= NOP_INSTR;
      ifid_pc   <= 32'd0;
      idex_ir   <= NOP_INSTR;
      idex_pc   <= 32'd0;
      idex_a    <= 32'd0;
      idex_b    <= 32'd0;
      exmem_ir  <= NOP_INSTR;
      exmem_alu <= 32'd0;
      exmem_b   <= 32'd0;
      memwb_ir  <= NOP_INSTR;
      memwb_val <= 32'd0;
    end else begin
      if (ex_taken) begin
        pc      <= ex_target;
        ifid_ir <= NOP_INSTR;
        idex_ir <= NOP_INSTR;
      end else if (stall) begin
        idex_ir <= NOP_INSTR;
      end else begin
        pc      <= (pc + 32'd4) & PC_MASK;
        ifid_ir <= imem[pc[IW+1:2]];
        ifid_pc <= pc;
        idex_ir <= ifid_ir;
      end
      idex_pc   <= ifid_pc;
      idex_a    <= id_a;
      idex_b    <= id_b;
      exmem_ir  <= idex_ir;
      exmem_alu <= ex_alu;
      exmem_b   <= ex_b;
      memwb_ir  <= exmem_ir;
      memwb_val <= mem_val;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
    end else if (wb_we) begin
      regs[wb_dest] <= memwb_val;
    end
  end

  // memories are loaded only while reset is held; stores need a live pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      if (ld_we && !ld_sel) imem[ld_addr[IW-1:0]] <= ld_wdata;
      if (ld_we && ld_sel)  dmem[ld_addr[DW-1:0]] <= ld_wdata;
    end else if (ir_op(exmem_ir) == OP_SW) begin
      dmem[dmem_idx] <= exmem_b;
    end
  end

endmodule

// File: tb/tb_mipspipe_fwd.sv
// Scoreboard bench for mipspipe_fwd: forwarding (FWD_EN=1) and interlock
// (FWD_EN=0) cores run the same programs; retires are checked in order.
module tb_mipspipe_fwd;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ld_we = 1'b0;
  logic        ld_sel = 1'b0;
  logic [9:0]  ld_addr = 10'd0;
  logic [31:0] ld_wdata = 32'd0;

  logic [31:0] pc0, pc1, ret_data0, ret_data1;
  logic        stall0, stall1, ret_valid0, ret_valid1;
  logic [4:0]  ret_reg0, ret_reg1;

  localparam logic [31:0] NOP = 32'h0000_0020;

  always #5 clock = ~clock;

  mipspipe_fwd dut0 (
    .clock(clock), .reset(reset), .ld_we(ld_we), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .pc_o(pc0), .stall_o(stall0),
    .ret_valid(ret_valid0), .ret_reg(ret_reg0), .ret_data(ret_data0)
  );

  mipspipe_fwd #(.FWD_EN(1'b0)) dut1 (
    .clock(clock), .reset(reset), .ld_we(ld_we), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .pc_o(pc1), .stall_o(stall1),
    .ret_valid(ret_valid1), .ret_reg(ret_reg1), .ret_data(ret_data1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int st0 = 0, st1 = 0;
  int first0 = -1, first1 = -1;
  logic [36:0] sb0[$];
  logic [36:0] sb1[$];
  logic [31:0] prog[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int f, input int rd, input int rs, input int rt);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, f[5:0]};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rt, input int rs, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  task automatic expect_ret(input int r, input logic [31:0] d);
    sb0.push_back({r[4:0], d});
    sb1.push_back({r[4:0], d});
  endtask

  initial forever begin
    @(posedge clock);
    cyc = reset ? 0 : cyc + 1;
  end

  initial begin : monitor
    logic [36:0] e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (stall0) st0++;
        if (stall1) st1++;
        if (ret_valid0) begin
          if (first0 < 0) first0 = cyc;
          if (sb0.size() == 0) chk("ret0_extra", 64'(ret_valid0), 64'd0);
          else begin
            e = sb0.pop_front();
            chk("ret0", 64'({ret_reg0, ret_data0}), 64'(e));
          end
        end else chk("ret0_idle", 64'({ret_reg0, ret_data0}), 64'd0);
        if (ret_valid1) begin
          if (first1 < 0) first1 = cyc;
          if (sb1.size() == 0) chk("ret1_extra", 64'(ret_valid1), 64'd0);
          else begin
            e = sb1.pop_front();
            chk("ret1", 64'({ret_reg1, ret_data1}), 64'(e));
          end
        end else chk("ret1_idle", 64'({ret_reg1, ret_data1}), 64'd0);
      end
    end
  end

  task automatic ld(input logic sel, input int addr, input logic [31:0] d);
    @(negedge clock);
    ld_we = 1'b1;
    ld_sel = sel;
    ld_addr = addr[9:0];
    ld_wdata = d;
  endtask

  task automatic load_prog();
    reset = 1'b1;
    for (int i = 0; i < 64; i++) ld(1'b0, i, (i < prog.size()) ? prog[i] : NOP);
  endtask

  task automatic release_rst();
    st0 = 0; st1 = 0; first0 = -1; first1 = -1;
    @(negedge clock);
    ld_we = 1'b0;
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    chk("drain0", 64'(sb0.size()), 64'd0);
    chk("drain1", 64'(sb1.size()), 64'd0);
    sb0.delete();
    sb1.delete();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_pc0", 64'(pc0), 64'd0);
    chk("rst_pc1", 64'(pc1), 64'd0);
    chk("rst_out0", 64'({stall0, ret_valid0, ret_reg0, ret_data0}), 64'd0);
    chk("rst_out1", 64'({stall1, ret_valid1, ret_reg1, ret_data1}), 64'd0);

    // program from the load/forward scenario, no nops
    prog = {rtype(32, 5, 2, 1), itype(35, 3, 5, 4), itype(35, 2, 2, 0),
            rtype(37, 3, 5, 3), itype(43, 3, 5, 0)};
    load_prog();
    ld(1'b1, 0, 32'hFFFF_FFF0);
    ld(1'b1, 1, 32'hFFFF_FFFF);
    expect_ret(5, 32'd3);
    expect_ret(3, 32'hFFFF_FFFF);
    expect_ret(2, 32'hFFFF_FFF0);
    expect_ret(3, 32'hFFFF_FFFF);
    release_rst();
    run(40);
    drain();
    chk("t1_dmem0_a", 64'(dut0.dmem[0]), 64'hFFFF_FFFF);
    chk("t1_dmem0_b", 64'(dut1.dmem[0]), 64'hFFFF_FFFF);

    // direct load-use: or consumes the lw result right behind it
    prog = {rtype(32, 5, 2, 1), itype(35, 3, 5, 4), rtype(37, 3, 5, 3), itype(43, 3, 5, 0)};
    load_prog();
    ld(1'b1, 0, 32'd0);
    ld(1'b1, 1, 32'hFFFF_FFFF);
    expect_ret(5, 32'd3);
    expect_ret(3, 32'hFFFF_FFFF);
    expect_ret(3, 32'hFFFF_FFFF);
    release_rst();
    run(40);
    drain();
    chk("lu_stall0", 64'(st0), 64'd1);
    chk("lu_stall1", 64'(st1), 64'd9);
    chk("lu_dmem0", 64'(dut0.dmem[0]), 64'hFFFF_FFFF);

    // back-to-back forwarding chain; interlock core stalls 3 per dependent pair
    prog = {rtype(32, 4, 1, 2), rtype(34, 6, 4, 3), rtype(36, 7, 6, 4)};
    load_prog();
    expect_ret(4, 32'd3);
    expect_ret(6, 32'd0);
    expect_ret(7, 32'd0);
    release_rst();
    run(40);
    drain();
    chk("fw_stall0", 64'(st0), 64'd0);
    chk("fw_stall1", 64'(st1), 64'd6);

    // taken beq skips two add $8 and lands on add $9 at 12
    prog = {itype(4, 1, 1, 2), rtype(32, 8, 1, 1), rtype(32, 8, 1, 1), rtype(32, 9, 1, 1)};
    load_prog();
    expect_ret(9, 32'd2);
    release_rst();
    run(3);
    chk("beq_pc0", 64'(pc0), 64'd12);
    chk("beq_pc1", 64'(pc1), 64'd12);
    run(37);
    drain();
    chk("beq_cyc0", 64'(first0), 64'd7);
    chk("beq_cyc1", 64'(first1), 64'd7);

    // not-taken beq: next instruction retires with no penalty
    prog = {itype(4, 2, 1, 5), rtype(32, 10, 1, 2)};
    load_prog();
    expect_ret(10, 32'd3);
    release_rst();
    run(40);
    drain();
    chk("bnt_cyc0", 64'(first0), 64'd5);
    chk("bnt_cyc1", 64'(first1), 64'd5);
    chk("bnt_stall0", 64'(st0), 64'd0);

    // reset while the sw is in EX: no store, state reinitialised
    prog = {rtype(32, 3, 1, 1), NOP, NOP, itype(43, 3, 0, 0)};
    load_prog();
    ld(1'b1, 0, 32'h5A5A_0001);
    expect_ret(3, 32'd2);
    release_rst();
    run(5);
    reset = 1'b1;
    #1;
    chk("mrst_pc0", 64'(pc0), 64'd0);
    chk("mrst_pc1", 64'(pc1), 64'd0);
    chk("mrst_out0", 64'({stall0, ret_valid0, ret_reg0, ret_data0}), 64'd0);
    drain();
    prog = {rtype(32, 0, 1, 1), rtype(32, 9, 3, 0)};
    load_prog();
    chk("mrst_dmem0", 64'(dut0.dmem[0]), 64'h5A5A_0001);
    chk("mrst_dmem1", 64'(dut1.dmem[0]), 64'h5A5A_0001);
    expect_ret(9, 32'd3);
    release_rst();
    run(30);
    drain();
    chk("mrst_dmem0_end", 64'(dut0.dmem[0]), 64'h5A5A_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
